// File: rtl/sc_fetch_pkg.sv
// Shared definitions for the single-cycle core fetch path.
package sc_defs;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sc_fetch_if.sv
// Fetch-to-decode handshake: head entry {pc, inst} with valid/ready.
interface sc_fetch_if;
    import sc_defs::*;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    modport master (
        output out_valid,
        output out_pc,
        output out_inst,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_inst,
        output out_ready
    );

endinterface

// File: rtl/sc_fetch_buf.sv
// Circular fetch buffer holding {pc, inst} pairs; flush empties it in one cycle.
module sc_fetch_buf #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_tail] <= wdata;
                r_tail        <= r_tail + AW'(1);
            end
            if (pop) begin
                r_head <= r_head + AW'(1);
            end
            // Simultaneous push and pop leaves the occupancy untouched, even when full.
            case ({push, pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_head];
    assign count = r_count;

endmodule

// File: rtl/sc_fetch.sv
// Instruction-fetch stage: PC register, redirect handling and fetch buffer control.
//   state | meaning
//   RUN   | fetching sequentially, accepting redirects
//   HALT  | misaligned redirect seen; PC frozen until reset
module sc_fetch
    import sc_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              clrn,
    output logic [XLEN-1:0]   imem_a,
    input  logic [XLEN-1:0]   imem_inst,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              misalign,
    sc_fetch_if.master        dec
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_misalign;

    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_misalign_nxt;
    logic            w_push;
    logic            w_flush;
    logic            w_pop;
    logic            w_can_push;
    logic [CW-1:0]   w_count;
    logic [63:0]     w_rdata;

    assign dec.out_valid = (w_count != '0);
    assign w_pop         = dec.out_valid & dec.out_ready;
    assign w_can_push    = (r_state == RUN) && ((w_count < CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = r_misalign;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            RUN: begin
                if (redirect) begin
                    // Redirect wins over push and pop; the head is dropped even if accepted.
                    w_flush = 1'b1;
                    if (is_word_aligned(redirect_pc)) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_pc_nxt       = {redirect_pc[XLEN-1:2], 2'b00};
                        w_misalign_nxt = 1'b1;
                        w_state_nxt    = HALT;
                    end
                end else if (w_can_push) begin
                    w_push   = 1'b1;
                    w_pc_nxt = r_pc + PC_STEP;
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    sc_fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .clrn  (clrn),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata ({r_pc, imem_inst}),
        .rdata (w_rdata),
        .count (w_count)
    );

    assign imem_a       = r_pc;
    assign misalign     = r_misalign;
    assign dec.out_pc   = w_rdata[63:32];
    assign dec.out_inst = w_rdata[31:0];

endmodule

// File: tb/tb_sc_fetch.sv
// Scoreboard bench for sc_fetch: directed stimulus queues expected accepts, a monitor checks them.
module tb_sc_fetch;

    logic        clk;
    logic        clrn;
    logic [31:0] imem_a;
    logic [31:0] imem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_pc_q [$];
    logic [31:0] exp_pc;

    sc_fetch_if dif ();

    sc_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .imem_a      (imem_a),
        .imem_inst   (imem_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .misalign    (misalign),
        .dec         (dif)
    );

    assign imem_inst = 32'hA000_0000 | imem_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_pc_q.push_back(pc);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake that decode really takes is compared against the queue.
    always @(negedge clk) begin
        if (clrn && dif.out_valid && dif.out_ready && !redirect) begin
            if (exp_pc_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_accept actual=%h required=none", dif.out_pc);
            end else begin
                exp_pc = exp_pc_q.pop_front();
                chk("accept_pc", dif.out_pc, exp_pc);
                chk("accept_inst", dif.out_inst, 32'hA000_0000 | exp_pc);
            end
        end
    end

    initial begin
        clrn          = 1'b0;
        dif.out_ready = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;

        #3;
        chk("reset_imem_a", imem_a, 32'h0);
        chk("reset_valid", {31'b0, dif.out_valid}, 32'h0);
        chk("reset_out_pc", dif.out_pc, 32'h0);
        chk("reset_out_inst", dif.out_inst, 32'h0);
        chk("reset_misalign", {31'b0, misalign}, 32'h0);

        // Stream from reset
        @(posedge clk);
        #1;
        clrn          = 1'b1;
        dif.out_ready = 1'b1;
        expect_pc(32'h00); expect_pc(32'h04); expect_pc(32'h08);
        repeat (4) cycle();

        // Backpressure: buffer fills with 0x0C, 0x10 and fetch stalls at 0x14
        dif.out_ready = 1'b0;
        repeat (5) cycle();
        chk("bp_imem_a", imem_a, 32'h14);
        chk("bp_valid", {31'b0, dif.out_valid}, 32'h1);
        chk("bp_head_pc", dif.out_pc, 32'h0C);
        chk("bp_head_inst", dif.out_inst, 32'hA000_000C);
        dif.out_ready = 1'b1;
        expect_pc(32'h0C); expect_pc(32'h10); expect_pc(32'h14);
        repeat (3) cycle();

        // Redirect while full and popping
        chk("pre_redir_head", dif.out_pc, 32'h18);
        redirect    = 1'b1;
        redirect_pc = 32'h64;
        expect_pc(32'h64); expect_pc(32'h68); expect_pc(32'h6C);
        cycle();
        redirect = 1'b0;
        chk("redir_bubble_valid", {31'b0, dif.out_valid}, 32'h0);
        chk("redir_imem_a", imem_a, 32'h64);
        repeat (4) cycle();

        // Misaligned redirect
        dif.out_ready = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 32'h66;
        cycle();
        redirect      = 1'b0;
        dif.out_ready = 1'b1;
        chk("mis_flag", {31'b0, misalign}, 32'h1);
        chk("mis_imem_a", imem_a, 32'h64);
        chk("mis_valid", {31'b0, dif.out_valid}, 32'h0);
        repeat (3) cycle();
        chk("halt_valid", {31'b0, dif.out_valid}, 32'h0);
        chk("halt_imem_a", imem_a, 32'h64);
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        cycle();
        redirect = 1'b0;
        cycle();
        chk("halt_ignore_imem_a", imem_a, 32'h64);
        chk("halt_ignore_valid", {31'b0, dif.out_valid}, 32'h0);
        chk("halt_ignore_misalign", {31'b0, misalign}, 32'h1);

        // Reset out of HALT, then wrap through the top of the address space
        clrn = 1'b0;
        #1;
        chk("rst_clears_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_imem_a", imem_a, 32'h0);
        @(posedge clk);
        #1;
        clrn          = 1'b1;
        redirect      = 1'b1;
        redirect_pc   = 32'hFFFF_FFFC;
        dif.out_ready = 1'b1;
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0000_0000); expect_pc(32'h0000_0004);
        cycle();
        redirect = 1'b0;
        chk("wrap_imem_a", imem_a, 32'hFFFF_FFFC);
        repeat (4) cycle();
        dif.out_ready = 1'b0;
        repeat (2) cycle();
        chk("mid_valid", {31'b0, dif.out_valid}, 32'h1);
        chk("mid_head_pc", dif.out_pc, 32'h08);

        // Asynchronous reset between edges
        #2;
        clrn = 1'b0;
        #1;
        chk("async_valid", {31'b0, dif.out_valid}, 32'h0);
        chk("async_misalign", {31'b0, misalign}, 32'h0);
        chk("async_imem_a", imem_a, 32'h0);
        chk("async_out_pc", dif.out_pc, 32'h0);
        chk("async_out_inst", dif.out_inst, 32'h0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        cycle();
        chk("post_rst_valid", {31'b0, dif.out_valid}, 32'h1);
        chk("post_rst_pc", dif.out_pc, 32'h0);
        chk("post_rst_inst", dif.out_inst, 32'hA000_0000);
        cycle();
        chk("queue_drained", exp_pc_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
